// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit for the P6 MIPS EX stage.
// Owns HI/LO and reports busy/stall so the hazard unit can freeze the pipe.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [3:0]  counter, counter_next;
  logic [63:0] temp, temp_next;
  logic        div_zero, div_zero_next;
  logic        busy_next, done_next;
  logic [31:0] hi_next, lo_next;

  logic        is_div;
  logic        div_ovf;
  logic [31:0] s_div, u_div;
  logic signed [31:0] sa, sd, s_quot, s_rem;
  logic [31:0] u_quot, u_rem;
  logic [63:0] sa64, sb64, ua64, ub64;
  logic [63:0] result;

  assign is_div  = op[1];
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Divisors are forced to 1 for the zero and overflow cases so the
  // divider never sees an undefined operation; those results are overridden.
  assign s_div = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
  assign u_div = (b == 32'd0) ? 32'd1 : b;
  assign sa    = a;
  assign sd    = s_div;

  assign sa64 = {{32{a[31]}}, a};
  assign sb64 = {{32{b[31]}}, b};
  assign ua64 = {32'd0, a};
  assign ub64 = {32'd0, b};

  always_comb begin
    s_quot = sa / sd;
    s_rem  = sa % sd;
    u_quot = a / u_div;
    u_rem  = a % u_div;
    case (op[1:0])
      2'd0:    result = sa64 * sb64;
      2'd1:    result = ua64 * ub64;
      2'd2:    result = div_ovf ? {32'd0, 32'h8000_0000} : {s_rem, s_quot};
      default: result = {u_rem, u_quot};
    endcase
  end

  assign stall_req = busy | (start & (op <= 3'd3));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      counter  <= 4'd0;
      temp     <= 64'd0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      state    <= state_next;
      counter  <= counter_next;
      temp     <= temp_next;
      div_zero <= div_zero_next;
      busy     <= busy_next;
      done     <= done_next;
      hi       <= hi_next;
      lo       <= lo_next;
    end
  end

  always_comb begin
    state_next    = state;
    counter_next  = counter;
    temp_next     = temp;
    div_zero_next = div_zero;
    busy_next     = busy;
    done_next     = 1'b0;
    hi_next       = hi;
    lo_next       = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              temp_next     = result;
              div_zero_next = is_div && (b == 32'd0);
              counter_next  = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              busy_next     = 1'b1;
              state_next    = RUN;
            end
            3'd4:    hi_next = a;
            3'd5:    lo_next = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Starts are ignored here; the counter alone decides when to commit.
        if (counter == 4'd1) begin
          if (!div_zero) begin
            hi_next = temp[63:32];
            lo_next = temp[31:0];
          end
          counter_next = 4'd0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = IDLE;
        end else begin
          counter_next = counter - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
